// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared sizes and FSM states for the matmul operand loader
package matmul_pkg;
  localparam int DWIDTH    = 16;
  localparam int ROW_ELEMS = 32;
  localparam int AWIDTH    = 7;
  localparam int ADDR_LEAD = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_DRAIN,
    S_RUN
  } state_t;
endpackage

// File: rtl/row_packer.sv
// rtl/row_packer.sv - packs a narrow element stream into full BRAM rows
module row_packer #(
  parameter int DWIDTH    = matmul_pkg::DWIDTH,
  parameter int ROW_ELEMS = matmul_pkg::ROW_ELEMS
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        accept,
  input  logic [DWIDTH-1:0]           elem,
  output logic [ROW_ELEMS*DWIDTH-1:0] row,
  output logic                        row_done
);
  localparam int EW = (ROW_ELEMS > 1) ? $clog2(ROW_ELEMS) : 1;
  localparam logic [EW-1:0] LAST = EW'(ROW_ELEMS - 1);

  logic [EW-1:0]               e_q;
  logic [ROW_ELEMS*DWIDTH-1:0] row_q;

  // Row as it looks with the current element inserted, so a commit captures the full row.
  always_comb begin
    row = row_q;
    row[int'(e_q) * DWIDTH +: DWIDTH] = elem;
  end

  assign row_done = accept && (e_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q   <= '0;
      row_q <= '0;
    end else if (clear) begin
      e_q   <= '0;
      row_q <= '0;
    end else if (accept) begin
      row_q <= row;
      e_q   <= row_done ? '0 : e_q + EW'(1);
    end
  end
endmodule

// File: rtl/matmul_operand_loader.sv
// rtl/matmul_operand_loader.sv - streams A/B rows into the matmul BRAM port, then starts the multiply
module matmul_operand_loader #(
  parameter int DWIDTH    = matmul_pkg::DWIDTH,
  parameter int ROW_ELEMS = matmul_pkg::ROW_ELEMS,
  parameter int AWIDTH    = matmul_pkg::AWIDTH,
  parameter int ADDR_LEAD = matmul_pkg::ADDR_LEAD
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cfg_go,
  input  logic [AWIDTH:0]             cfg_num_rows,
  input  logic                        in_valid,
  input  logic [DWIDTH-1:0]           in_data,
  output logic                        in_ready,
  output logic                        enable_writing_to_mem,
  output logic [AWIDTH-1:0]           addr_pi,
  output logic [ROW_ELEMS*DWIDTH-1:0] data_pi,
  output logic                        we_a,
  output logic                        we_b,
  output logic                        start_mat_mul_0,
  input  logic                        done_mat_mul,
  output logic                        busy,
  output logic                        run_done
);
  import matmul_pkg::*;

  localparam int RW  = ROW_ELEMS * DWIDTH;
  localparam int CW  = AWIDTH + 1;
  localparam int DCW = $clog2(ADDR_LEAD + 2) + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    rows_q, r_q;
  logic [DCW-1:0]   drain_q;
  logic [ADDR_LEAD-1:0] pipe_q;
  logic [RW-1:0]    row_buf_q, packed_row;
  logic             buf_b_q;
  logic             accept, row_done, last_row, run_end;

  assign accept   = in_valid && in_ready;
  assign last_row = (r_q == rows_q - CW'(1));
  assign run_end  = (state_q == S_RUN) && done_mat_mul;

  row_packer #(.DWIDTH(DWIDTH), .ROW_ELEMS(ROW_ELEMS)) u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_q == S_IDLE),
    .accept   (accept),
    .elem     (in_data),
    .row      (packed_row),
    .row_done (row_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_go && (cfg_num_rows != '0)) state_d = S_LOAD_A;
      S_LOAD_A: if (row_done && last_row) state_d = S_LOAD_B;
      S_LOAD_B: if (row_done && last_row) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q == DCW'(ADDR_LEAD + 1)) state_d = S_RUN;
      S_RUN:    if (done_mat_mul) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q               <= S_IDLE;
      rows_q                <= '0;
      r_q                   <= '0;
      drain_q               <= '0;
      pipe_q                <= '0;
      row_buf_q             <= '0;
      buf_b_q               <= 1'b0;
      in_ready              <= 1'b0;
      enable_writing_to_mem <= 1'b0;
      addr_pi               <= '0;
      data_pi               <= '0;
      we_a                  <= 1'b0;
      we_b                  <= 1'b0;
      start_mat_mul_0       <= 1'b0;
      busy                  <= 1'b0;
      run_done              <= 1'b0;
    end else begin
      state_q               <= state_d;
      in_ready              <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
      enable_writing_to_mem <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B) || (state_d == S_DRAIN);
      start_mat_mul_0       <= (state_d == S_RUN);
      // busy stays up through the run_done cycle even though the FSM is already idle.
      busy                  <= (state_d != S_IDLE) || run_end;
      run_done              <= run_end;

      if ((state_q == S_IDLE) && (state_d == S_LOAD_A)) begin
        rows_q <= cfg_num_rows;
        r_q    <= '0;
      end else if (row_done) begin
        addr_pi   <= r_q[AWIDTH-1:0];
        r_q       <= last_row ? '0 : r_q + CW'(1);
        row_buf_q <= packed_row;
        buf_b_q   <= (state_q == S_LOAD_B);
      end

      drain_q <= (state_q == S_DRAIN) ? drain_q + DCW'(1) : '0;

      // Data and strobe trail the address by ADDR_LEAD cycles to match the matmul address pipeline.
      pipe_q <= ADDR_LEAD'({pipe_q, row_done});
      we_a   <= pipe_q[ADDR_LEAD-1] && !buf_b_q;
      we_b   <= pipe_q[ADDR_LEAD-1] && buf_b_q;
      if (pipe_q[ADDR_LEAD-1]) data_pi <= row_buf_q;
    end
  end
endmodule

// File: tb/tb_matmul_operand_loader.sv
// tb/tb_matmul_operand_loader.sv - directed bench with row scoreboard for matmul_operand_loader
module tb_matmul_operand_loader;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cfg_go = 1'b0;
  logic [7:0]   cfg_num_rows = '0;
  logic         in_valid = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_ready;
  logic         enable_writing_to_mem;
  logic [6:0]   addr_pi;
  logic [511:0] data_pi;
  logic         we_a, we_b;
  logic         start_mat_mul_0;
  logic         done_mat_mul = 1'b0;
  logic         busy, run_done;

  int checks = 0;
  int failures = 0;
  int strobes = 0;

  typedef struct {
    logic         is_b;
    logic [6:0]   addr;
    logic [511:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [6:0] addr_d1 = '0, addr_d2 = '0;

  matmul_operand_loader dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .cfg_go                (cfg_go),
    .cfg_num_rows          (cfg_num_rows),
    .in_valid              (in_valid),
    .in_data               (in_data),
    .in_ready              (in_ready),
    .enable_writing_to_mem (enable_writing_to_mem),
    .addr_pi               (addr_pi),
    .data_pi               (data_pi),
    .we_a                  (we_a),
    .we_b                  (we_b),
    .start_mat_mul_0       (start_mat_mul_0),
    .done_mat_mul          (done_mat_mul),
    .busy                  (busy),
    .run_done              (run_done)
  );

  always #5 clk = ~clk;

  // Every write strobe is matched against the oldest expected row; addr_pi is taken two cycles before the strobe.
  always @(negedge clk) begin
    if (we_a || we_b) begin
      strobes++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL wr_unexpected observed we=%b%b addr=%0d expected no strobe", we_a, we_b, addr_d2);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        checks++;
        assert ({we_a, we_b, addr_d2, data_pi} === {!mon_e.is_b, mon_e.is_b, mon_e.addr, mon_e.data}) else begin
          failures++;
          $error("FAIL wr_row observed we=%b%b addr=%0d data=%h expected we=%b%b addr=%0d data=%h",
                 we_a, we_b, addr_d2, data_pi, !mon_e.is_b, mon_e.is_b, mon_e.addr, mon_e.data);
        end
      end
    end
    addr_d2 = addr_d1;
    addr_d1 = addr_pi;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] out_vec();
    return {in_ready, enable_writing_to_mem, we_a, we_b, start_mat_mul_0, busy, run_done,
            |addr_pi, |data_pi};
  endfunction

  task automatic expect_rows(input int rows, input int base);
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < rows; r++) begin
        e.is_b = (m == 1);
        e.addr = 7'(r);
        for (int k = 0; k < 32; k++) e.data[k*16 +: 16] = 16'(base + (m*rows + r)*32 + k);
        sb.push_back(e);
      end
    end
  endtask

  task automatic start_run(input string tag, input int rows);
    cfg_num_rows = 8'(rows);
    cfg_go = 1'b1;
    @(posedge clk); #1;
    cfg_go = 1'b0;
    @(negedge clk);
    chk({tag, "_go_busy"}, {in_ready, busy}, 2'b11);
    @(posedge clk); #1;
  endtask

  task automatic stream(input string tag, input int rows, input int base, input int duty,
                        input int go_at, input int stop_at);
    int total, i, cyc;
    bit acc;
    total = 2 * rows * 32;
    if (stop_at >= 0 && stop_at < total) total = stop_at;
    i = 0;
    cyc = 0;
    while (i < total && cyc < 30000) begin
      in_valid = ($urandom_range(99) < duty);
      in_data  = 16'(base + i);
      cfg_go   = (i == go_at);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    cfg_go   = 1'b0;
    chk({tag, "_accepted"}, i, total);
  endtask

  task automatic finish_run(input string tag, input int rows, input int s0);
    int lat;
    lat = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == 4) chk({tag, "_en_before_start"}, enable_writing_to_mem, 1);
      if (start_mat_mul_0) break;
    end
    chk({tag, "_start_latency"}, lat, 5);
    chk({tag, "_en_at_start"}, enable_writing_to_mem, 0);
    chk({tag, "_strobes"}, strobes - s0, 2 * rows);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    repeat (20) @(negedge clk);
    chk({tag, "_start_held"}, {start_mat_mul_0, busy, run_done}, 3'b110);
    @(posedge clk); #1;
    done_mat_mul = 1'b1;
    @(posedge clk); #1;
    done_mat_mul = 1'b0;
    @(negedge clk);
    chk({tag, "_run_done"}, {start_mat_mul_0, busy, run_done}, 3'b011);
    @(negedge clk);
    chk({tag, "_idle_after"}, {start_mat_mul_0, busy, run_done}, 3'b000);
    @(posedge clk); #1;
  endtask

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), 9'h0);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_outputs", out_vec(), 9'h0);
    end
    @(posedge clk); #1;

    cfg_num_rows = 8'd0;
    cfg_go = 1'b1;
    @(posedge clk); #1;
    cfg_go = 1'b0;
    @(negedge clk);
    chk("zero_rows_go", {busy, in_ready}, 2'b00);
    @(posedge clk); #1;

    s0 = strobes;
    start_run("single", 1);
    expect_rows(1, 0);
    stream("single", 1, 0, 100, -1, -1);
    finish_run("single", 1, s0);

    s0 = strobes;
    start_run("align", 4);
    expect_rows(4, 'h100);
    stream("align", 4, 'h100, 100, -1, -1);
    finish_run("align", 4, s0);

    s0 = strobes;
    start_run("gaps", 3);
    expect_rows(3, 'h200);
    stream("gaps", 3, 'h200, 30, -1, -1);
    finish_run("gaps", 3, s0);

    s0 = strobes;
    start_run("full", 128);
    expect_rows(128, 'h4000);
    stream("full", 128, 'h4000, 100, -1, -1);
    finish_run("full", 128, s0);

    s0 = strobes;
    start_run("go_in_b", 2);
    expect_rows(2, 'h300);
    stream("go_in_b", 2, 'h300, 100, 2*32 + 5, -1);
    finish_run("go_in_b", 2, s0);

    // Reset lands while row 0 of A is still in the delay pipeline.
    s0 = strobes;
    start_run("abort", 2);
    expect_rows(2, 'h500);
    stream("abort", 2, 'h500, 100, -1, 33);
    reset_n = 1'b0;
    #1;
    chk("abort_async_zero", out_vec(), 9'h0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 10; c++) @(negedge clk);
    chk("abort_no_strobes", strobes - s0, 0);
    chk("abort_idle", {busy, in_ready, enable_writing_to_mem}, 3'b000);
    @(posedge clk); #1;

    s0 = strobes;
    start_run("after_reset", 2);
    expect_rows(2, 'h600);
    stream("after_reset", 2, 'h600, 100, -1, -1);
    finish_run("after_reset", 2, s0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
